// File: rtl/nor_reduce_pkg.sv
// rtl/nor_reduce_pkg.sv - shared constants and tree-geometry helpers for nor_reduce_pipe
package nor_reduce_pkg;

    localparam logic [1:0] MODE_NOR  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_AND  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;

    localparam int COUNT_W = 16;

    function automatic int ipow(input int base, input int exp);
        int r;
        r = 1;
        for (int i = 0; i < exp; i++) r = r * base;
        return r;
    endfunction

    // ceil(log_radix(width)); always at least one level because width >= 2
    function automatic int calc_levels(input int width, input int radix);
        int lv;
        int p;
        lv = 0;
        p  = 1;
        while (p < width) begin
            p  = p * radix;
            lv = lv + 1;
        end
        return lv;
    endfunction

    // Bit offset of tree level lvl inside a flat vector holding levels 0..levels
    function automatic int level_off(input int radix, input int levels, input int lvl);
        int off;
        off = 0;
        for (int k = 0; k < lvl; k++) off = off + ipow(radix, levels - k);
        return off;
    endfunction

    function automatic int tree_nodes(input int radix, input int levels);
        return level_off(radix, levels, levels) + 1;
    endfunction

endpackage

// File: rtl/nor_reduce_lane.sv
// rtl/nor_reduce_lane.sv - one lane: capture inversion, padded registered OR tree, final inversion
module nor_reduce_lane
    import nor_reduce_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int RADIX  = 3,
    parameter int LEVELS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       mode,
    output logic             zn
);

    localparam int LEAVES = ipow(RADIX, LEVELS);
    localparam int NODES  = tree_nodes(RADIX, LEVELS);

    // All levels live in one flat vector: leaves at bit 0, the root at NODES-1
    logic [NODES-1:0]  tree_q, tree_d;
    logic [LEVELS-1:0] fin_inv_q, fin_inv_d;
    logic              node;

    always_comb begin
        tree_d    = tree_q;
        fin_inv_d = fin_inv_q;
        node      = 1'b0;
        if (adv) begin
            // Padding is zero after the capture inversion so it never disturbs the OR
            for (int i = 0; i < LEAVES; i++) tree_d[i] = 1'b0;
            for (int i = 0; i < WIDTH; i++) tree_d[i] = a[i] ^ mode[1];
            fin_inv_d[0] = ~mode[0];
            for (int l = 1; l < LEVELS; l++) fin_inv_d[l] = fin_inv_q[l-1];
            for (int l = 1; l <= LEVELS; l++) begin
                for (int j = 0; j < ipow(RADIX, LEVELS - l); j++) begin
                    node = 1'b0;
                    for (int k = 0; k < RADIX; k++)
                        node = node | tree_q[level_off(RADIX, LEVELS, l - 1) + j * RADIX + k];
                    if (l == LEVELS)
                        tree_d[level_off(RADIX, LEVELS, l) + j] = node ^ fin_inv_q[LEVELS-1];
                    else
                        tree_d[level_off(RADIX, LEVELS, l) + j] = node;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tree_q    <= '0;
            fin_inv_q <= '0;
        end else begin
            tree_q    <= tree_d;
            fin_inv_q <= fin_inv_d;
        end
    end

    assign zn = tree_q[NODES-1];

endmodule

// File: rtl/nor_reduce_pipe.sv
// rtl/nor_reduce_pipe.sv - multi-lane pipelined NOR/OR/AND/NAND reducer with flow control, HIT and COUNT
module nor_reduce_pipe
    import nor_reduce_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 4,
    parameter int RADIX    = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [CHANNELS*WIDTH-1:0] A,
    input  logic [1:0]                MODE,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [CHANNELS-1:0]       ZN,
    output logic [CHANNELS-1:0]       HIT,
    output logic [COUNT_W-1:0]        COUNT,
    input  logic                      CLR
);

    localparam int LEVELS = calc_levels(WIDTH, RADIX);

    logic [LEVELS:0]       vld_q, vld_d;
    logic [CHANNELS-1:0]   hit_q, hit_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic                  stall;
    logic                  adv;
    logic                  hs;

    assign OUT_VALID = vld_q[LEVELS];
    assign stall     = vld_q[LEVELS] & ~OUT_READY;
    assign adv       = ~stall;
    assign IN_READY  = adv;
    assign hs        = vld_q[LEVELS] & OUT_READY;

    always_comb begin
        vld_d = vld_q;
        if (adv) vld_d = {vld_q[LEVELS-1:0], IN_VALID};
    end

    // Clear first, then let a same-cycle handshake contribute
    always_comb begin
        count_d = CLR ? '0 : count_q;
        hit_d   = CLR ? '0 : hit_q;
        if (hs) begin
            hit_d = hit_d | ZN;
            if (count_d != {COUNT_W{1'b1}}) count_d = count_d + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q   <= '0;
            hit_q   <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            hit_q   <= hit_d;
            count_q <= count_d;
        end
    end

    assign HIT   = hit_q;
    assign COUNT = count_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        nor_reduce_lane #(
            .WIDTH  (WIDTH),
            .RADIX  (RADIX),
            .LEVELS (LEVELS)
        ) u_lane (
            .clk  (CLK),
            .rst  (RST),
            .adv  (adv),
            .a    (A[c*WIDTH +: WIDTH]),
            .mode (MODE),
            .zn   (ZN[c])
        );
    end

endmodule

// File: tb/tb_nor_reduce_pipe.sv
// tb/tb_nor_reduce_pipe.sv - randomized scoreboard bench for nor_reduce_pipe
module tb_nor_reduce_pipe;
    import nor_reduce_pkg::*;

    localparam int LAT_REGS = 3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] a;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  zn;
    logic [3:0]  hit;
    logic [15:0] count;
    logic        clr;

    logic        w5_in_valid;
    logic        w5_in_ready;
    logic [4:0]  w5_a;
    logic        w5_out_valid;
    logic [0:0]  w5_zn;
    logic [0:0]  w5_hit;
    logic [15:0] w5_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stall_cnt = 0;

    typedef struct {
        logic [3:0] zn;
        int         acc;
        int         stl;
    } beat_t;

    beat_t       sb[$];
    int          exp_count = 0;
    logic [3:0]  exp_hit = '0;
    logic        stalled_prev = 1'b0;
    logic [3:0]  held_zn = '0;

    nor_reduce_pipe u_dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .A         (a),
        .MODE      (mode),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .ZN        (zn),
        .HIT       (hit),
        .COUNT     (count),
        .CLR       (clr)
    );

    nor_reduce_pipe #(.WIDTH(5), .CHANNELS(1), .RADIX(2)) u_w5 (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (w5_in_valid),
        .IN_READY  (w5_in_ready),
        .A         (w5_a),
        .MODE      (MODE_AND),
        .OUT_VALID (w5_out_valid),
        .OUT_READY (1'b1),
        .ZN        (w5_zn),
        .HIT       (w5_hit),
        .COUNT     (w5_count),
        .CLR       (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_zn(input logic [47:0] av, input logic [1:0] m);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) begin
            logic [11:0] v;
            logic any_set, all_set;
            v = av[c*12 +: 12];
            any_set = (v != 0);
            all_set = (v == 12'hFFF);
            case (m)
                MODE_NOR: r[c] = !any_set;
                MODE_OR:  r[c] = any_set;
                MODE_AND: r[c] = all_set;
                default:  r[c] = !all_set;
            endcase
        end
        return r;
    endfunction

    function automatic logic [11:0] rand_lane();
        logic [11:0] v;
        case ($urandom_range(0, 4))
            0: v = 12'h000;
            1: v = 12'hFFF;
            2: v = 12'h001 << $urandom_range(0, 11);
            3: v = ~(12'h001 << $urandom_range(0, 11));
            default: v = 12'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic [47:0] rand_a();
        return {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
    endfunction

    // Scoreboard: observe handshakes mid-cycle, predict the effect of the next edge
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_count    = 0;
            exp_hit      = '0;
            stalled_prev = 1'b0;
        end else begin
            chk("count", 32'(count), 32'(exp_count));
            chk("hit", 32'(hit), 32'(exp_hit));
            chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (stalled_prev) chk("zn_hold", 32'(zn), 32'(held_zn));
            if (out_valid && !out_ready) begin
                stalled_prev = 1'b1;
                held_zn      = zn;
                stall_cnt++;
            end else begin
                stalled_prev = 1'b0;
            end
            if (clr) begin
                exp_count = 0;
                exp_hit   = '0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_beat", 32'(1), 32'(0));
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("zn", 32'(zn), 32'(e.zn));
                    chk("latency", 32'(cyc), 32'(e.acc + 1 + LAT_REGS + (stall_cnt - e.stl)));
                    exp_hit = exp_hit | e.zn;
                    if (exp_count < 65535) exp_count++;
                end
            end
            if (in_valid && in_ready) sb.push_back('{ref_zn(a, mode), cyc, stall_cnt});
        end
    end

    task automatic drive(input logic v, input logic [47:0] av, input logic [1:0] m,
                         input logic rdy, input logic c);
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = av;
        mode      = m;
        out_ready = rdy;
        clr       = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 48'h0, MODE_NOR, 1'b1, 1'b0);
    endtask

    initial begin
        int  guard;
        logic found;
        rst = 1'b1; in_valid = 1'b0; a = '0; mode = MODE_NOR; out_ready = 1'b1; clr = 1'b0;
        w5_in_valid = 1'b0; w5_a = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_zn", 32'(zn), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_hit", 32'(hit), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // single NOR beat
        drive(1'b1, {12'h000, 12'h800, 12'h001, 12'h000}, MODE_NOR, 1'b1, 1'b0);
        idle(4);
        chk("t1_valid", 32'(out_valid), 32'(1));
        chk("t1_zn", 32'(zn), 32'(4'b1001));
        idle(1);
        chk("t1_valid_once", 32'(out_valid), 32'(0));
        idle(3);
        chk("t1_count", 32'(count), 32'(1));
        chk("t1_hit", 32'(hit), 32'(4'b1001));

        // back-to-back modes on one data pattern
        drive(1'b1, {12'hFFF, 12'h000, 12'hFFE, 12'hFFF}, MODE_OR, 1'b1, 1'b0);
        drive(1'b1, {12'hFFF, 12'h000, 12'hFFE, 12'hFFF}, MODE_AND, 1'b1, 1'b0);
        drive(1'b1, {12'hFFF, 12'h000, 12'hFFE, 12'hFFF}, MODE_NAND, 1'b1, 1'b0);
        idle(2);
        chk("t2_or", 32'(zn), 32'(4'b1011));
        idle(1);
        chk("t2_and", 32'(zn), 32'(4'b1001));
        idle(1);
        chk("t2_nand", 32'(zn), 32'(4'b0110));
        chk("t2_valid", 32'(out_valid), 32'(1));
        idle(4);

        // random traffic with back-pressure and occasional clears
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, rand_a(), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        idle(8);

        // 5-cycle stall with 6 beats offered
        for (int i = 0; i < 10; i++)
            drive(i < 6, rand_a(), 2'($urandom_range(0, 3)), !(i >= 3 && i < 8), 1'b0);
        idle(8);
        chk("stall_drained", 32'(sb.size()), 32'(0));

        // reset with beats in flight
        for (int i = 0; i < 3; i++) drive(1'b1, rand_a(), MODE_NOR, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_zn", 32'(zn), 32'(0));
        chk("mid_rst_count", 32'(count), 32'(0));
        chk("mid_rst_hit", 32'(hit), 32'(0));
        idle(8);

        // saturation of COUNT
        guard = 0;
        while (exp_count < 65534 && guard < 70000) begin
            drive(1'b1, rand_a(), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
            guard++;
        end
        chk("sat_preload", 32'(count), 32'(16'hFFFE));
        repeat (3) drive(1'b1, rand_a(), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
        chk("sat_reach", 32'(count), 32'(16'hFFFF));
        repeat (2) drive(1'b1, rand_a(), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
        chk("sat_hold", 32'(count), 32'(16'hFFFF));
        idle(8);

        // CLR coinciding with a handshake
        drive(1'b1, {12'h001, 12'h000, 12'h010, 12'h100}, MODE_NOR, 1'b1, 1'b0);
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            idle(1);
            if (out_valid) begin
                clr   = 1'b1;
                found = 1'b1;
            end
        end
        chk("clr_beat_seen", 32'(found), 32'(1));
        idle(1);
        chk("clr_hs_count", 32'(count), 32'(1));
        chk("clr_hs_hit", 32'(hit), 32'(4'b0100));

        // non-power width lane: WIDTH=5, RADIX=2, AND mode
        @(posedge clk);
        #1 w5_in_valid = 1'b1; w5_a = 5'b11111;
        @(posedge clk);
        #1 w5_a = 5'b11110;
        @(posedge clk);
        #1 w5_in_valid = 1'b0; w5_a = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("w5_valid", 32'(w5_out_valid), 32'(1));
        chk("w5_all_ones", 32'(w5_zn), 32'(1));
        @(posedge clk);
        #1;
        chk("w5_one_zero", 32'(w5_zn), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("w5_count", 32'(w5_count), 32'(2));
        chk("w5_hit", 32'(w5_hit), 32'(1));
        chk("w5_in_ready", 32'(w5_in_ready), 32'(1));

        idle(2);
        chk("final_drained", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
